// File: rtl/stage_10.sv
`timescale 1ns/1ps
// stage_10: final radix-2 stage of a 1024-point FFT.
// Each input pair (A, B) is taken with stride 512. B is rotated by W_1024^j with a
// pipelined CORDIC, and a butterfly forms (A+B')/2 and (A-B')/2. The results go into a
// ping-pong RAM that is read out in natural bin order, two bins per cycle.
module stage_10 (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid_in,
    input  logic [31:0] i_data_a_real,
    input  logic [31:0] i_data_a_imag,
    input  logic [31:0] i_data_b_real,
    input  logic [31:0] i_data_b_imag,
    output logic        o_valid_out,
    output logic [31:0] o_data_a_real,
    output logic [31:0] o_data_a_imag,
    output logic [31:0] o_data_b_real,
    output logic [31:0] o_data_b_imag,
    output logic [9:0]  o_bin_index,
    output logic        o_sof,
    output logic        o_eof
);
    // CORDIC datapath: 4 fractional guard bits plus headroom; angles in 2^32 units per turn
    localparam int CW  = 38;
    localparam int NIT = 22;
    localparam logic signed [65:0] KINV    = 66'sd2608131496;   // 1/K * 2^32
    localparam logic signed [31:0] QUARTER = 32'sh4000_0000;     // 90 degrees
    localparam logic signed [31:0] ATAN [0:NIT-1] = '{
        32'sd536870912, 32'sd316933406, 32'sd167458907, 32'sd85004756,
        32'sd42667331,  32'sd21354465,  32'sd10679838,  32'sd5340245,
        32'sd2670163,   32'sd1335087,   32'sd667544,    32'sd333772,
        32'sd166886,    32'sd83443,     32'sd41722,     32'sd20861,
        32'sd10430,     32'sd5215,      32'sd2608,      32'sd1304,
        32'sd652,       32'sd326
    };

    logic [8:0]         tw_cnt_q;
    logic               in_valid_q;
    logic [23:0]        vld_sr_q;
    logic               bf_valid;
    logic signed [31:0] in_a_re_q, in_a_im_q, in_b_re_q, in_b_im_q;
    logic signed [31:0] angle_q;
    logic signed [32:0] pre_x, pre_y;
    logic signed [31:0] pre_z;
    logic signed [CW-1:0] cx_q [0:NIT];
    logic signed [CW-1:0] cy_q [0:NIT];
    logic signed [31:0] cz_q [0:NIT-1];
    logic signed [31:0] a_re_dly_q [0:22];
    logic signed [31:0] a_im_dly_q [0:22];
    logic signed [31:0] b_rot_re, b_rot_im;
    logic signed [31:0] bf_sum_re_q, bf_sum_im_q, bf_diff_re_q, bf_diff_im_q;
    logic [31:0]        ram_re [0:2047];
    logic [31:0]        ram_im [0:2047];
    logic [31:0]        ram_a_re_q, ram_a_im_q, ram_b_re_q, ram_b_im_q;
    logic [8:0]         wr_cnt_q, rd_cnt_q, s1_m_q, s2_m_q;
    logic               wr_bank_q, rd_bank_q, rd_active_q, s1_bank_q;
    logic               s1_valid_q, s2_valid_q;
    logic               frame_done;

    assign bf_valid   = vld_sr_q[23];
    assign frame_done = bf_valid && (wr_cnt_q == 9'd511);

    // Twiddle counter, input-valid register and the 24-stage valid shift (CORDIC + butterfly)
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tw_cnt_q   <= '0;
            in_valid_q <= 1'b0;
            vld_sr_q   <= '0;
        end else begin
            in_valid_q <= i_valid_in;
            vld_sr_q   <= {vld_sr_q[22:0], in_valid_q};
            if (i_valid_in) tw_cnt_q <= tw_cnt_q + 9'd1;
        end
    end

    // Bring the angle within CORDIC convergence by a +/-90 degree pre-rotation of B
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pre_x = 33'(in_b_re_q);
        pre_y = 33'(in_b_im_q);
        pre_z = angle_q;
        if (angle_q < -QUARTER) begin
            pre_x = 33'(in_b_im_q);
            pre_y = -33'(in_b_re_q);
            pre_z = angle_q + QUARTER;
        end else if (angle_q > QUARTER) begin
            pre_x = -33'(in_b_im_q);
            pre_y = 33'(in_b_re_q);
            pre_z = angle_q - QUARTER;
        end
    end

    assign b_rot_re = 32'((cx_q[NIT] + 38'sd8) >>> 4);
    assign b_rot_im = 32'((cy_q[NIT] + 38'sd8) >>> 4);

    // Datapath: input/ROM register, CORDIC stages, A delay line and scaled butterfly
    always_ff @(posedge i_clk) begin
        // NOTE: pure datapath registers carry no reset; only control/valid state is cleared.
        in_a_re_q <= $signed(i_data_a_real);
        in_a_im_q <= $signed(i_data_a_imag);
        in_b_re_q <= $signed(i_data_b_real);
        in_b_im_q <= $signed(i_data_b_imag);
        angle_q   <= -$signed({1'b0, tw_cnt_q, 22'd0});   // ROM: W_1024^j angle = -j/1024 turn

        cx_q[0] <= CW'(($signed({{33{pre_x[32]}}, pre_x}) * KINV) >>> 28);
        cy_q[0] <= CW'(($signed({{33{pre_y[32]}}, pre_y}) * KINV) >>> 28);
        cz_q[0] <= pre_z;
        for (int i = 0; i < NIT; i++) begin
            if (!cz_q[i][31]) begin
                cx_q[i+1] <= cx_q[i] - (cy_q[i] >>> i);
                cy_q[i+1] <= cy_q[i] + (cx_q[i] >>> i);
            end else begin
                cx_q[i+1] <= cx_q[i] + (cy_q[i] >>> i);
                cy_q[i+1] <= cy_q[i] - (cx_q[i] >>> i);
            end
        end
        for (int i = 0; i < NIT - 1; i++) begin
            cz_q[i+1] <= cz_q[i][31] ? cz_q[i] + ATAN[i] : cz_q[i] - ATAN[i];
        end

        a_re_dly_q[0] <= in_a_re_q;
        a_im_dly_q[0] <= in_a_im_q;
        for (int i = 1; i < 23; i++) begin
            a_re_dly_q[i] <= a_re_dly_q[i-1];
            a_im_dly_q[i] <= a_im_dly_q[i-1];
        end

        bf_sum_re_q  <= 32'((33'(a_re_dly_q[22]) + 33'(b_rot_re)) >>> 1);
        bf_sum_im_q  <= 32'((33'(a_im_dly_q[22]) + 33'(b_rot_im)) >>> 1);
        bf_diff_re_q <= 32'((33'(a_re_dly_q[22]) - 33'(b_rot_re)) >>> 1);
        bf_diff_im_q <= 32'((33'(a_im_dly_q[22]) - 33'(b_rot_im)) >>> 1);
    end

    // Ping-pong RAM: write sum at j and diff at j+512, read bins 2m and 2m+1
    always_ff @(posedge i_clk) begin
        if (bf_valid) begin
            ram_re[{wr_bank_q, 1'b0, wr_cnt_q}] <= bf_sum_re_q;
            ram_im[{wr_bank_q, 1'b0, wr_cnt_q}] <= bf_sum_im_q;
            ram_re[{wr_bank_q, 1'b1, wr_cnt_q}] <= bf_diff_re_q;
            ram_im[{wr_bank_q, 1'b1, wr_cnt_q}] <= bf_diff_im_q;
        end
        ram_a_re_q <= ram_re[{s1_bank_q, s1_m_q, 1'b0}];
        ram_a_im_q <= ram_im[{s1_bank_q, s1_m_q, 1'b0}];
        ram_b_re_q <= ram_re[{s1_bank_q, s1_m_q, 1'b1}];
        ram_b_im_q <= ram_im[{s1_bank_q, s1_m_q, 1'b1}];
    end

    // Write counter, bank swap, autonomous read sequencer and read-side pipeline
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_cnt_q      <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_active_q   <= 1'b0;
            rd_cnt_q      <= '0;
            s1_valid_q    <= 1'b0;
            s1_m_q        <= '0;
            s1_bank_q     <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_m_q        <= '0;
            o_valid_out   <= 1'b0;
            o_bin_index   <= '0;
            o_sof         <= 1'b0;
            o_eof         <= 1'b0;
            o_data_a_real <= '0;
            o_data_a_imag <= '0;
            o_data_b_real <= '0;
            o_data_b_imag <= '0;
        end else begin
            if (bf_valid) wr_cnt_q <= wr_cnt_q + 9'd1;
            if (frame_done) begin
                wr_bank_q <= ~wr_bank_q;
                rd_bank_q <= wr_bank_q;
            end

            // A new frame takes priority so a swap on the last read (m=511) leaves no gap
            if (frame_done) begin
                rd_active_q <= 1'b1;
                rd_cnt_q    <= '0;
            end else if (rd_active_q) begin
                rd_cnt_q <= rd_cnt_q + 9'd1;
                if (rd_cnt_q == 9'd511) rd_active_q <= 1'b0;
            end

            s1_valid_q <= rd_active_q;
            s1_m_q     <= rd_cnt_q;
            s1_bank_q  <= rd_bank_q;
            s2_valid_q <= s1_valid_q;
            s2_m_q     <= s1_m_q;

            o_valid_out <= s2_valid_q;
            o_sof       <= s2_valid_q && (s2_m_q == 9'd0);
            o_eof       <= s2_valid_q && (s2_m_q == 9'd511);
            if (s2_valid_q) begin
                o_bin_index   <= {s2_m_q, 1'b0};
                o_data_a_real <= ram_a_re_q;
                o_data_a_imag <= ram_a_im_q;
                o_data_b_real <= ram_b_re_q;
                o_data_b_imag <= ram_b_im_q;
            end
        end
    end
endmodule
